// File: rtl/des_round_controller.sv
// Sequencing FSM for an iterative single-round DES datapath: IP load, 16 rounds,
// final permutation capture, output handshake. Optional abort input via DES_CTRL_ABORT_EN.
//
// state | meaning
// IDLE  | ready for a block; load_ip follows in_valid
// ROUND | one Feistel round per cycle, round_idx 0..ROUNDS-1
// FINAL | output register captures the inverse permutation
// DONE  | out_valid held until out_ready
module des_round_controller #(
    parameter int ROUNDS = 16,
    parameter int RND_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DES_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             decrypt,
    output logic             load_ip,
    output logic             round_en,
    output logic [RND_W-1:0] round_idx,
    output logic [1:0]       key_shift,
    output logic             key_dir,
    output logic             fp_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             dec_q, dec_d;
    logic             abort_w;

`ifdef DES_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Decrypt walks the schedule backwards: round 0 uses the unrotated PC1 key.
    function automatic logic [1:0] shift_amount(input logic [RND_W-1:0] idx,
                                                input logic dec);
        logic [1:0] amt;
        if (int'(idx) == 0)
            amt = dec ? 2'd0 : 2'd1;
        else if (int'(idx) == 1 || int'(idx) == 8 || int'(idx) == 15)
            amt = 2'd1;
        else
            amt = 2'd2;
        return amt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        dec_d     = dec_q;
        in_ready  = 1'b0;
        load_ip   = 1'b0;
        round_en  = 1'b0;
        round_idx = '0;
        key_shift = 2'd0;
        key_dir   = 1'b0;
        fp_load   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                load_ip  = in_valid;
                round_d  = '0;
                dec_d    = 1'b0;
                if (in_valid) begin
                    dec_d   = decrypt;
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                round_en  = 1'b1;
                round_idx = round_q;
                key_shift = shift_amount(round_q, dec_q);
                key_dir   = dec_q;
                if (abort_w) begin
                    state_d = S_IDLE;
                    round_d = '0;
                    dec_d   = 1'b0;
                end else if (round_q == RND_W'(ROUNDS - 1)) begin
                    state_d = S_FINAL;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end

            S_FINAL: begin
                key_dir = dec_q;
                fp_load = ~abort_w;
                round_d = '0;
                if (abort_w) begin
                    state_d = S_IDLE;
                    dec_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                key_dir   = dec_q;
                out_valid = 1'b1;
                // abort takes precedence over a simultaneous out_ready handshake
                if (abort_w || out_ready) begin
                    state_d = S_IDLE;
                    round_d = '0;
                    dec_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                round_d = '0;
                dec_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_des_round_controller.sv
// Table-driven bench for des_round_controller: per-cycle input/expected-output vectors
// covering encrypt, decrypt, backpressure, mid-block reset and (optionally) abort.
module tb_des_round_controller;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       decrypt;
    logic       load_ip;
    logic       round_en;
    logic [3:0] round_idx;
    logic [1:0] key_shift;
    logic       key_dir;
    logic       fp_load;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef DES_CTRL_ABORT_EN
    logic       abort;
`endif

    des_round_controller #(.ROUNDS(16), .RND_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DES_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decrypt   (decrypt),
        .load_ip   (load_ip),
        .round_en  (round_en),
        .round_idx (round_idx),
        .key_shift (key_shift),
        .key_dir   (key_dir),
        .fp_load   (fp_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       in_ready;
        logic       load_ip;
        logic       round_en;
        logic [3:0] idx;
        logic [1:0] ks;
        logic       dir;
        logic       fp;
        logic       ov;
        logic       busy;
    } out_t;

    typedef struct {
        logic rst;
        logic iv;
        logic dec;
        logic ordy;
        logic ab;
        out_t exp;
    } vec_t;

    vec_t vecs [400];
    int   nv;
    int   errors;
    int   checks;
    int   enc_ks [16];
    int   dec_ks [16];
    logic run_done;

    function automatic out_t mk(input logic inr, input logic ld, input logic ren,
                                input int idx, input int ks, input logic dir,
                                input logic fp, input logic ov, input logic bsy);
        out_t o;
        o.in_ready = inr;
        o.load_ip  = ld;
        o.round_en = ren;
        o.idx      = 4'(idx);
        o.ks       = 2'(ks);
        o.dir      = dir;
        o.fp       = fp;
        o.ov       = ov;
        o.busy     = bsy;
        return o;
    endfunction

    task automatic add(input logic r, input logic iv, input logic d, input logic ordy,
                       input logic ab, input out_t e);
        vecs[nv].rst  = r;
        vecs[nv].iv   = iv;
        vecs[nv].dec  = d;
        vecs[nv].ordy = ordy;
        vecs[nv].ab   = ab;
        vecs[nv].exp  = e;
        nv++;
    endtask

    task automatic add_idle(input logic iv, input logic d);
        add(1'b0, iv, d, 1'b0, 1'b0, mk(1'b1, iv, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic add_round(input int i, input logic dir, input logic iv, input logic d,
                             input logic r, input logic ab);
        int ks;
        ks = dir ? dec_ks[i] : enc_ks[i];
        add(r, iv, d, 1'b0, ab, mk(1'b0, 1'b0, 1'b1, i, ks, dir, 1'b0, 1'b0, 1'b1));
    endtask

    // Whole block from accept to the IDLE cycle after the output handshake.
    task automatic add_block(input logic d, input logic toggle, input int bp,
                             input logic ab_done);
        add_idle(1'b1, d);
        for (int i = 0; i < 16; i++)
            add_round(i, d, (i == 6), (toggle && i >= 4) ? ~d : d, 1'b0, 1'b0);
        add(1'b0, 1'b0, d, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0, 0, d, 1'b1, 1'b0, 1'b1));
        for (int j = 0; j < bp; j++)
            add(1'b0, (j % 2 == 0), ~d, 1'b0, 1'b0,
                mk(1'b0, 1'b0, 1'b0, 0, 0, d, 1'b0, 1'b1, 1'b1));
        add(1'b0, 1'b0, d, 1'b1, ab_done, mk(1'b0, 1'b0, 1'b0, 0, 0, d, 1'b0, 1'b1, 1'b1));
        add_idle(1'b0, 1'b0);
    endtask

    initial begin
        run_done = 1'b0;
        repeat (2000) @(posedge clk);
        if (!run_done) begin
            errors++;
            $display("FAIL timeout: vector run did not complete within 2000 cycles");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        out_t act;
        for (int i = 0; i < 16; i++) begin
            enc_ks[i] = shifts[i];
            dec_ks[i] = (i == 0) ? 0 : shifts[i];
        end
        nv     = 0;
        errors = 0;
        checks = 0;

        // reset state, then encrypt with out_ready high
        add_idle(1'b0, 1'b0);
        add_idle(1'b0, 1'b1);
        add_block(1'b0, 1'b0, 0, 1'b0);
        // decrypt with mid-block toggle and 10 cycles of backpressure
        add_block(1'b1, 1'b1, 10, 1'b0);
        // reset at T+9: T+1..T+8 are rounds 0..7, T+9 is round 8 with rst asserted
        add_idle(1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            add_round(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_round(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_idle(1'b0, 1'b0);
        add_idle(1'b0, 1'b0);
        add_block(1'b0, 1'b0, 0, 1'b0);
`ifdef DES_CTRL_ABORT_EN
        // abort at T+4 (round 3) -> IDLE at T+5
        add_idle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            add_round(i, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_round(3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        add_idle(1'b0, 1'b0);
        // abort together with out_ready in DONE
        add_block(1'b0, 1'b0, 2, 1'b1);
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        decrypt   = 1'b0;
        out_ready = 1'b0;
`ifdef DES_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);

        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            round_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b ov=%b idx=%0d, want rdy=1 busy=0 ov=0 idx=0",
                     in_ready, busy, out_valid, round_idx);
        end

        for (int k = 0; k < nv; k++) begin
            @(negedge clk);
            rst       = vecs[k].rst;
            in_valid  = vecs[k].iv;
            decrypt   = vecs[k].dec;
            out_ready = vecs[k].ordy;
`ifdef DES_CTRL_ABORT_EN
            abort     = vecs[k].ab;
`endif
            #1;
            act = {in_ready, load_ip, round_en, round_idx, key_shift, key_dir,
                   fp_load, out_valid, busy};
            checks++;
            if (act !== vecs[k].exp) begin
                errors++;
                $display("FAIL vec%0d: got rdy=%b ld=%b ren=%b idx=%0d ks=%0d dir=%b fp=%b ov=%b busy=%b, want rdy=%b ld=%b ren=%b idx=%0d ks=%0d dir=%b fp=%b ov=%b busy=%b",
                         k, act.in_ready, act.load_ip, act.round_en, act.idx, act.ks,
                         act.dir, act.fp, act.ov, act.busy,
                         vecs[k].exp.in_ready, vecs[k].exp.load_ip, vecs[k].exp.round_en,
                         vecs[k].exp.idx, vecs[k].exp.ks, vecs[k].exp.dir,
                         vecs[k].exp.fp, vecs[k].exp.ov, vecs[k].exp.busy);
            end
        end

        run_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
